cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit CPU.
- Steps every instruction through fetch, decode and execute/memory/branch phases.
- Consumes the instruction decoder's classification outputs (op, instr_type, is_load, RI flag) and the ALU flag register.
- Drives the enables and selects for PC, IR, register file, ALU operand mux, flag register and data memory. Sits between the decoder and the datapath.

Parameters:
- PC_W, 16, width of PC-related count outputs (retired-instruction counter width).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- run  input  1  1 = allowed to start a new fetch; 0 = hold in FETCH
- instr_type  input  2  from decoder: 00 R-type/ALU, 01 STORE, 10 LOAD, 11 jump/branch
- is_load  input  1  from decoder (cross-check for LOAD)
- op  input  8  decoder instruction_out (ALU opcode or jump/branch code)
- ri_in  input  1  decoder RI flag: 0 register operand, 1 immediate
- z_flag  input  1  zero flag from flag register
- n_flag  input  1  signed-less-than flag from flag register
- ir_en  output  1  latch instruction register
- pc_en  output  1  update PC
- pc_sel  output  2  00 PC+1, 01 PC+imm (relative), 10 imm (absolute)
- mem_addr_sel  output  1  0 PC, 1 register address
- mem_we  output  1  data memory write strobe
- reg_we  output  1  register file write enable
- wb_sel  output  1  0 ALU result, 1 memory read data
- alu_imm_sel  output  1  ALU B operand: 0 register, 1 immediate
- flag_en  output  1  load flag register from ALU
- state  output  3  current state, for debug
- instr_count  output  PC_W  retired-instruction counter

Behaviour:
- States:
  - FETCH=0
  - FETCH_WAIT=1
  - DECODE=2
  - EXEC=3
  - MEM=4
  - LOAD_WB=5
  - BRANCH=6
  - Encoding 7 is unused and returns to FETCH.
- Reset: state=FETCH, instr_count=0, all strobes 0, pc_sel=00, selects 0. Reset asserted mid-instruction aborts it: no pc_en, reg_we or mem_we is issued.
- FETCH:
  - mem_addr_sel=0.
  - run=1 -> FETCH_WAIT; run=0 -> stay in FETCH.
  - run is sampled only in FETCH; an instruction in flight always completes.
- FETCH_WAIT: memory has 1-cycle read latency; ir_en=1 -> DECODE.
- DECODE:
  - Latch instr_type, op, ri_in into internal registers.
  - Next state by instr_type: 00 -> EXEC, 01/10 -> MEM, 11 -> BRANCH.
  - instr_type is authoritative; op values shared between LOAD and conditional-jump codes are never used to classify.
  - instr_type=10 with is_load=0 is treated as LOAD.
- EXEC:
  - alu_imm_sel=latched RI, flag_en=1, pc_en=1, pc_sel=00.
  - reg_we=1 except when latched op is CMP (8'b00001011), where reg_we=0.
  - -> FETCH.
- MEM:
  - mem_addr_sel=1.
  - STORE: mem_we=1, pc_en=1, pc_sel=00, -> FETCH.
  - LOAD: mem_we=0, -> LOAD_WB.
- LOAD_WB: wb_sel=1, reg_we=1, pc_en=1, pc_sel=00, mem_addr_sel=1 held -> FETCH.
- BRANCH:
  - pc_en=1.
  - Condition from latched op[3:0]: 0000 EQ z; 0001 NE !z; 0110 GT n; 0111 LE !n; 1110 UC always; any other code never taken.
  - Taken: pc_sel = op[7] ? 01 (relative) : 10 (absolute).
  - Not taken: pc_sel=00.
  - -> FETCH.
- Flags are sampled in the BRANCH cycle; a flag_en from the previous instruction's EXEC is already visible.
- Outputs are Moore: a function of state and the latched decode fields. All strobes are 0 in every state not listed for them.
- Latency: ALU, STORE and BRANCH take 4 cycles; LOAD takes 5 cycles; each further cycle with run=0 adds 1.
- instr_count increments by 1 on every cycle with pc_en=1, wraps from 2^PC_W-1 to 0, and is cleared only by reset.

Test Plan:
- Reset, then run=1 with ADD (instr_type=00, op=8'h05, ri=0).
  - States go 0,1,2,3,0.
  - EXEC cycle: reg_we=1, flag_en=1, pc_en=1, pc_sel=00, alu_imm_sel=0.
  - instr_count=1.
- CMPI (instr_type=00, op=8'h0B, ri=1): EXEC has reg_we=0, flag_en=1, alu_imm_sel=1.
- LOAD (instr_type=10, op=8'h40) followed by STORE (instr_type=01, op=8'h44).
  - LOAD takes 5 cycles; LOAD_WB has wb_sel=1, reg_we=1.
  - STORE MEM cycle has mem_we=1, mem_addr_sel=1.
  - The 8'h40 op is not treated as a jump.
- Conditional branches:
  - Branch op=8'hC0 with z=1 -> pc_sel=01.
  - Same op with z=0 -> pc_sel=00.
  - Jump op=8'h47 with n=0 -> pc_sel=10.
  - op=8'hC3 -> pc_sel=00 (never taken).
- run=0 held 3 cycles in FETCH: state stays 0, all strobes 0. Raise run: the fetch proceeds the next cycle.
- Wrap and abort:
  - Preload 65535 retirements; the next retirement gives instr_count=0.
  - Assert reset during MEM of a STORE: mem_we never pulses; state=0 and instr_count=0 immediately (asynchronous).

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit CPU: walks each instruction through
// fetch, decode and execute/memory/branch, driving datapath enables and selects.
module cpu_control_fsm #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [1:0]      instr_type,
  input  logic            is_load,
  input  logic [7:0]      op,
  input  logic            ri_in,
  input  logic            z_flag,
  input  logic            n_flag,
  output logic            ir_en,
  output logic            pc_en,
  output logic [1:0]      pc_sel,
  output logic            mem_addr_sel,
  output logic            mem_we,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            alu_imm_sel,
  output logic            flag_en,
  output logic [2:0]      state,
  output logic [PC_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXEC       = 3'd3,
    S_MEM        = 3'd4,
    S_LOAD_WB    = 3'd5,
    S_BRANCH     = 3'd6
  } state_t;

  localparam logic [7:0] OP_CMP     = 8'b0000_1011;
  localparam logic [1:0] TYPE_ALU   = 2'b00;
  localparam logic [1:0] TYPE_STORE = 2'b01;
  localparam logic [1:0] TYPE_JUMP  = 2'b11;

  state_t          r_state;
  logic [1:0]      r_type;
  logic [7:0]      r_op;
  logic            r_ri;
  logic [PC_W-1:0] r_count;
  logic            w_taken;

  // instr_type alone classifies the instruction, so the decoder's is_load is not consulted.
  logic w_unused_is_load;
  assign w_unused_is_load = is_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_type  <= 2'b00;
      r_op    <= 8'h00;
      r_ri    <= 1'b0;
      r_count <= '0;
    end else begin
      if (pc_en) r_count <= r_count + PC_W'(1);
      case (r_state)
        S_FETCH:      if (run) r_state <= S_FETCH_WAIT;
        S_FETCH_WAIT: r_state <= S_DECODE;
        S_DECODE: begin
          r_type <= instr_type;
          r_op   <= op;
          r_ri   <= ri_in;
          if (instr_type == TYPE_ALU)       r_state <= S_EXEC;
          else if (instr_type == TYPE_JUMP) r_state <= S_BRANCH;
          else                              r_state <= S_MEM;
        end
        S_MEM:   r_state <= (r_type == TYPE_STORE) ? S_FETCH : S_LOAD_WB;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Branch condition uses the live flags so an update from the previous EXEC is honoured.
  always_comb begin
    w_taken = 1'b0;
    case (r_op[3:0])
      4'b0000: w_taken = z_flag;
      4'b0001: w_taken = ~z_flag;
      4'b0110: w_taken = n_flag;
      4'b0111: w_taken = ~n_flag;
      4'b1110: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 2'b00;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    alu_imm_sel  = 1'b0;
    flag_en      = 1'b0;
    case (r_state)
      S_FETCH_WAIT: ir_en = 1'b1;
      S_EXEC: begin
        alu_imm_sel = r_ri;
        flag_en     = 1'b1;
        pc_en       = 1'b1;
        reg_we      = (r_op != OP_CMP);
      end
      S_MEM: begin
        mem_addr_sel = 1'b1;
        if (r_type == TYPE_STORE) begin
          mem_we = 1'b1;
          pc_en  = 1'b1;
        end
      end
      S_LOAD_WB: begin
        mem_addr_sel = 1'b1;
        wb_sel       = 1'b1;
        reg_we       = 1'b1;
        pc_en        = 1'b1;
      end
      S_BRANCH: begin
        pc_en = 1'b1;
        if (w_taken) pc_sel = r_op[7] ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: table of instructions plus hand sequences,
// with per-cycle expectations queued at drive time and checked on the falling edge.
module tb_cpu_control_fsm;

  localparam logic [9:0] O_IR  = 10'b10_00_000000;
  localparam logic [9:0] O_PC  = 10'b01_00_000000;
  localparam logic [9:0] O_ABS = 10'b00_10_000000;
  localparam logic [9:0] O_REL = 10'b00_01_000000;
  localparam logic [9:0] O_MA  = 10'b00_00_100000;
  localparam logic [9:0] O_WE  = 10'b00_00_010000;
  localparam logic [9:0] O_RW  = 10'b00_00_001000;
  localparam logic [9:0] O_WB  = 10'b00_00_000100;
  localparam logic [9:0] O_IMM = 10'b00_00_000010;
  localparam logic [9:0] O_FL  = 10'b00_00_000001;

  typedef struct {
    logic [1:0] typ;
    logic       ld;
    logic [7:0] op;
    logic       ri;
    logic       z;
    logic       n;
    logic [2:0] st_a;
    logic [9:0] out_a;
    logic [2:0] st_b;
    logic [9:0] out_b;
    logic       two;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [9:0]  outs;
    logic [15:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic reset, run, is_load, ri_in, z_flag, n_flag;
  logic [1:0] instr_type;
  logic [7:0] op;
  logic ir_en, pc_en, mem_addr_sel, mem_we, reg_we, wb_sel, alu_imm_sel, flag_en;
  logic [1:0] pc_sel;
  logic [2:0] state;
  logic [15:0] instr_count;
  logic s_ir_en, s_pc_en, s_mem_addr_sel, s_mem_we, s_reg_we, s_wb_sel, s_alu_imm_sel, s_flag_en;
  logic [1:0] s_pc_sel;
  logic [2:0] s_state;
  logic [3:0] s_count;

  logic [9:0] w_outs;
  assign w_outs = {ir_en, pc_en, pc_sel, mem_addr_sel, mem_we, reg_we, wb_sel, alu_imm_sel, flag_en};

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_count = 16'd0;
  rec_t q[$];
  vec_t tbl[20];

  always #5 clk = ~clk;

  cpu_control_fsm #(.PC_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_type(instr_type), .is_load(is_load),
    .op(op), .ri_in(ri_in), .z_flag(z_flag), .n_flag(n_flag),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .mem_addr_sel(mem_addr_sel),
    .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel), .alu_imm_sel(alu_imm_sel),
    .flag_en(flag_en), .state(state), .instr_count(instr_count)
  );

  // Narrow counter instance shares the stimulus so wrap-around is reached quickly.
  cpu_control_fsm #(.PC_W(4)) dut_small (
    .clk(clk), .reset(reset), .run(run), .instr_type(instr_type), .is_load(is_load),
    .op(op), .ri_in(ri_in), .z_flag(z_flag), .n_flag(n_flag),
    .ir_en(s_ir_en), .pc_en(s_pc_en), .pc_sel(s_pc_sel), .mem_addr_sel(s_mem_addr_sel),
    .mem_we(s_mem_we), .reg_we(s_reg_we), .wb_sel(s_wb_sel), .alu_imm_sel(s_alu_imm_sel),
    .flag_en(s_flag_en), .state(s_state), .instr_count(s_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic [9:0] o);
    rec_t r;
    r.st   = st;
    r.outs = o;
    r.cnt  = exp_count;
    q.push_back(r);
    if (o[8]) exp_count = exp_count + 16'd1;
  endtask

  task automatic set_in(input vec_t v);
    instr_type = v.typ;
    is_load    = v.ld;
    op         = v.op;
    ri_in      = v.ri;
    z_flag     = v.z;
    n_flag     = v.n;
    run        = 1'b1;
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH.
  task automatic run_vec(input vec_t v);
    set_in(v);
    push(3'd0, 10'd0);
    push(3'd1, O_IR);
    push(3'd2, 10'd0);
    push(v.st_a, v.out_a);
    if (v.two) push(v.st_b, v.out_b);
    $display("instr type=%b op=%h ri=%b z=%b n=%b expect st=%0d outs=%b",
             v.typ, v.op, v.ri, v.z, v.n, v.st_a, v.out_a);
    repeat (v.two ? 5 : 4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      rec_t r;
      r = q.pop_front();
      chk("cycle_state_outs", 32'({state, w_outs}), 32'({r.st, r.outs}));
      chk("instr_count", 32'({instr_count, s_count}), 32'({r.cnt, r.cnt[3:0]}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b00, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 3'd3, O_PC|O_RW|O_FL,       3'd0, 10'd0, 1'b0};
    tbl[1]  = '{2'b00, 1'b0, 8'h0B, 1'b1, 1'b0, 1'b0, 3'd3, O_PC|O_IMM|O_FL,      3'd0, 10'd0, 1'b0};
    tbl[2]  = '{2'b10, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 3'd4, O_MA, 3'd5, O_MA|O_WB|O_RW|O_PC, 1'b1};
    tbl[3]  = '{2'b01, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 3'd4, O_MA|O_WE|O_PC,       3'd0, 10'd0, 1'b0};
    tbl[4]  = '{2'b11, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b0, 3'd6, O_PC|O_REL,           3'd0, 10'd0, 1'b0};
    tbl[5]  = '{2'b11, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 3'd6, O_PC,                 3'd0, 10'd0, 1'b0};
    tbl[6]  = '{2'b11, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0, 3'd6, O_PC|O_ABS,           3'd0, 10'd0, 1'b0};
    tbl[7]  = '{2'b11, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 3'd6, O_PC,                 3'd0, 10'd0, 1'b0};
    tbl[8]  = '{2'b10, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 3'd4, O_MA, 3'd5, O_MA|O_WB|O_RW|O_PC, 1'b1};
    tbl[9]  = '{2'b00, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 3'd3, O_PC|O_RW|O_IMM|O_FL, 3'd0, 10'd0, 1'b0};
    tbl[10] = '{2'b11, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 3'd6, O_PC|O_ABS,           3'd0, 10'd0, 1'b0};
    tbl[11] = '{2'b11, 1'b0, 8'h8E, 1'b0, 1'b0, 1'b0, 3'd6, O_PC|O_REL,           3'd0, 10'd0, 1'b0};
    tbl[12] = '{2'b11, 1'b0, 8'h06, 1'b0, 1'b0, 1'b1, 3'd6, O_PC|O_ABS,           3'd0, 10'd0, 1'b0};
    tbl[13] = '{2'b11, 1'b0, 8'h86, 1'b0, 1'b1, 1'b0, 3'd6, O_PC,                 3'd0, 10'd0, 1'b0};
    tbl[14] = '{2'b11, 1'b0, 8'h87, 1'b0, 1'b0, 1'b1, 3'd6, O_PC,                 3'd0, 10'd0, 1'b0};
    tbl[15] = '{2'b00, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 3'd3, O_PC|O_RW|O_FL,       3'd0, 10'd0, 1'b0};
    tbl[16] = '{2'b00, 1'b0, 8'hCB, 1'b0, 1'b0, 1'b0, 3'd3, O_PC|O_RW|O_FL,       3'd0, 10'd0, 1'b0};
    tbl[17] = '{2'b01, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 3'd4, O_MA|O_WE|O_PC,       3'd0, 10'd0, 1'b0};
    tbl[18] = '{2'b11, 1'b0, 8'h0E, 1'b0, 1'b0, 1'b0, 3'd6, O_PC|O_ABS,           3'd0, 10'd0, 1'b0};
    tbl[19] = '{2'b00, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b0, 3'd3, O_PC|O_FL,            3'd0, 10'd0, 1'b0};

    reset = 1'b1; run = 1'b0; instr_type = 2'b00; is_load = 1'b0;
    op = 8'h00; ri_in = 1'b0; z_flag = 1'b0; n_flag = 1'b0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(w_outs), 32'd0);
    chk("reset_count", 32'({instr_count, s_count}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Table pass: 20 retirements, so the 4-bit counter wraps along the way.
    for (int i = 0; i < 20; i++) run_vec(tbl[i]);

    // run=0 holds in FETCH for three cycles, then a raised run fetches immediately.
    run = 1'b0;
    $display("idle run=0 for 3 cycles");
    for (int i = 0; i < 3; i++) push(3'd0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    run_vec(tbl[0]);

    // run dropped mid-instruction: the ADD still completes, then the FSM idles.
    set_in(tbl[0]);
    $display("instr ADD with run dropped after fetch");
    push(3'd0, 10'd0); push(3'd1, O_IR); push(3'd2, 10'd0);
    push(3'd3, O_PC|O_RW|O_FL); push(3'd0, 10'd0); push(3'd0, 10'd0);
    @(posedge clk);
    #1 run = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Flag updated only once BRANCH is reached must still decide the branch.
    set_in(tbl[5]);
    $display("branch op=C0 with z rising in BRANCH cycle");
    push(3'd0, 10'd0); push(3'd1, O_IR); push(3'd2, 10'd0); push(3'd6, O_PC|O_REL);
    repeat (3) @(posedge clk);
    #1 z_flag = 1'b1;
    @(posedge clk);
    #1 z_flag = 1'b0;

    // Asynchronous reset during the MEM cycle of a STORE aborts it.
    set_in(tbl[3]);
    $display("store aborted by reset in MEM");
    push(3'd0, 10'd0); push(3'd1, O_IR); push(3'd2, 10'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_count", 32'({instr_count, s_count}), 32'd0);
    chk("abort_strobes", 32'({mem_we, pc_en, reg_we}), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_mem_we", 32'({mem_we, state}), 32'd0);
    reset = 1'b0;
    exp_count = 16'd0;
    run_vec(tbl[0]);

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
